// File: rtl/inst_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : inst_issue_queue
//  Purpose  : Instruction front-end. Buffers instruction words in a DEPTH-entry
//             FIFO, tracks in-flight destination indices in a busy-bit
//             scoreboard, and presents the head word to the core only when
//             none of its A/B/C indices is busy (RAW/WAW protection).
//             NOP words (opcode 0) are dropped at the head without issue.
//  Ports    : clk        - system clock, rising edge
//             rstn       - synchronous active-low reset
//             in_inst    - pushed word {opcode, A, B, C, addr}
//             in_valid   - producer has a word
//             in_ready   - queue has room (count != DEPTH)
//             out_inst   - head word, 0 while empty
//             out_valid  - head is a non-NOP without hazard
//             out_ready  - core accepts the head
//             done_valid - core retired an instruction
//             done_idx   - destination index of the retired instruction
//             flush      - synchronous clear of FIFO and scoreboard
//             count      - FIFO occupancy
//             stall_cnt  - (ISSUE_STALL_CNT_EN) cycles stalled on a hazard
//             issue_cnt  - (ISSUE_STALL_CNT_EN) number of issues
//  Options  : define ISSUE_STALL_CNT_EN to add the saturating stall/issue
//             counters.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_issue_queue #(
    parameter int OPC_WIDTH  = 3,
    parameter int IDX_WIDTH  = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 8,
    localparam int INST_WIDTH = OPC_WIDTH + 3*IDX_WIDTH + ADDR_WIDTH,
    localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [INST_WIDTH-1:0] in_inst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  done_valid,
    input  logic [IDX_WIDTH-1:0]  done_idx,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  count
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           issue_cnt
`endif
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int SB_SIZE   = 2**IDX_WIDTH;

    // Bit offsets of the index fields inside an instruction word
    localparam int C_LSB = ADDR_WIDTH;
    localparam int B_LSB = ADDR_WIDTH + IDX_WIDTH;
    localparam int A_LSB = ADDR_WIDTH + 2*IDX_WIDTH;

    logic [INST_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [SB_SIZE-1:0]    r_busy;

    logic [INST_WIDTH-1:0] w_head;
    logic [OPC_WIDTH-1:0]  w_opc;
    logic [IDX_WIDTH-1:0]  w_a;
    logic [IDX_WIDTH-1:0]  w_b;
    logic [IDX_WIDTH-1:0]  w_c;
    logic                  w_empty;
    logic                  w_is_nop;
    logic                  w_hazard;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_nop_pop;
    logic                  w_pop;

    assign w_head   = r_mem[r_rd_ptr];
    assign w_opc    = w_head[INST_WIDTH-1 -: OPC_WIDTH];
    assign w_a      = w_head[A_LSB +: IDX_WIDTH];
    assign w_b      = w_head[B_LSB +: IDX_WIDTH];
    assign w_c      = w_head[C_LSB +: IDX_WIDTH];

    assign w_empty  = (r_count == '0);
    assign w_is_nop = (w_opc == '0);
    // Only registered busy bits are consulted; a retire this cycle is seen next cycle.
    assign w_hazard = r_busy[w_a] | r_busy[w_b] | r_busy[w_c];

    assign in_ready  = (r_count != CNT_WIDTH'(DEPTH));
    assign out_valid = !w_empty && !w_is_nop && !w_hazard;
    assign out_inst  = w_empty ? '0 : w_head;
    assign count     = r_count;

    // Full queue never accepts, even when the head leaves in the same cycle.
    assign w_push    = in_valid && in_ready && !flush;
    assign w_issue   = out_valid && out_ready;
    assign w_nop_pop = !w_empty && w_is_nop;
    assign w_pop     = w_issue || w_nop_pop;

    // Storage is not cleared; out_inst is masked while empty instead.
    always_ff @(posedge clk) begin
        if (rstn && w_push) begin
            r_mem[r_wr_ptr] <= in_inst;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Set is written after clear so an issue and a retire of the same index
    // in one cycle leave the index busy.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            r_busy <= '0;
        end else begin
            if (done_valid) begin
                r_busy[done_idx] <= 1'b0;
            end
            if (w_issue) begin
                r_busy[w_c] <= 1'b1;
            end
        end
    end

`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_issue_cnt;
    logic        w_stall;

    assign w_stall = !w_empty && !w_is_nop && w_hazard;

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_issue && (r_issue_cnt != '1)) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign issue_cnt = r_issue_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_issue_queue
//  Purpose  : Directed self-checking bench for inst_issue_queue at default
//             parameters (27-bit words, 8-entry FIFO, 16-entry scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_issue_queue;

    logic        clk;
    logic        rstn;
    logic [26:0] in_inst;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] out_inst;
    logic        out_valid;
    logic        out_ready;
    logic        done_valid;
    logic [3:0]  done_idx;
    logic        flush;
    logic [3:0]  count;
`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] issue_cnt;
`endif

    int errors = 0;
    int checks = 0;

    inst_issue_queue dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_inst    (in_inst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_inst   (out_inst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .done_valid (done_valid),
        .done_idx   (done_idx),
        .flush      (flush),
        .count      (count)
`ifdef ISSUE_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .issue_cnt  (issue_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [26:0] mk(input logic [2:0] o, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c,
                                       input logic [11:0] ad);
        return {o, a, b, c, ad};
    endfunction

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        flush = 1'b1; in_valid = 1'b0; done_valid = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_inst = '0; in_valid = 1'b0; out_ready = 1'b0;
        done_valid = 1'b0; done_idx = '0; flush = 1'b0;
        repeat (5) tick();
        rstn = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (out_inst !== 27'd0) begin errors++; $display("FAIL reset_out_inst: got %h want 0", out_inst); end
    endtask

    task automatic test_single_issue();
        logic [26:0] w;
        w = mk(3'd1, 4'd1, 4'd2, 4'd3, 12'h000);
        out_ready = 1'b1; in_inst = w; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        checks++; if (out_inst !== w) begin errors++; $display("FAIL single_inst: got %h want %h", out_inst, w); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", count); end
        tick();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after: got %b want 0", out_valid); end
    endtask

    task automatic test_raw_hazard();
        logic [26:0] p, q;
        clear_all();
        p = mk(3'd1, 4'd1, 4'd2, 4'd3, 12'h111);
        q = mk(3'd2, 4'd3, 4'd4, 4'd5, 12'h222);
        out_ready = 1'b1; in_inst = p; in_valid = 1'b1;
        tick();
        in_inst = q;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_stall: got %b want 0", out_valid); end
        checks++; if (out_inst !== q) begin errors++; $display("FAIL raw_head: got %h want %h", out_inst, q); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_stall2: got %b want 0", out_valid); end
        done_valid = 1'b1; done_idx = 4'd3;
        tick();
        done_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL raw_release: got %b want 1", out_valid); end
`ifdef ISSUE_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL raw_stall_cnt: got %0d want 2", stall_cnt); end
`endif
        tick();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL raw_drain: got %0d want 0", count); end
`ifdef ISSUE_STALL_CNT_EN
        checks++; if (issue_cnt !== 32'd2) begin errors++; $display("FAIL raw_issue_cnt: got %0d want 2", issue_cnt); end
`endif
    endtask

    task automatic test_full_and_back_to_back();
        logic [26:0] w [8];
        clear_all();
        // One dummy pass so the 8 entries straddle the pointer wrap.
        out_ready = 1'b1; in_inst = mk(3'd1, 4'd1, 4'd1, 4'd2, 12'hABC); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w[i] = mk(3'((i % 7) + 1), 4'd0, 4'd0, 4'(8 + i), 12'(i * 16 + 1));
            in_inst = w[i]; in_valid = 1'b1;
            tick();
        end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        in_inst = mk(3'd3, 4'd0, 4'd0, 4'd1, 12'hFFF);
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_ninth: got %0d want 8", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_inst !== w[i] || out_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_issue%0d: got %h/%b want %h/1", i, out_inst, out_valid, w[i]);
            end
            tick();
        end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL b2b_drain: got %0d want 0", count); end
        checks++; if (out_inst !== 27'd0) begin errors++; $display("FAIL b2b_empty_inst: got %h want 0", out_inst); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_set_wins();
        clear_all();
        out_ready = 1'b1; in_inst = mk(3'd1, 4'd1, 4'd2, 4'd5, 12'h010); in_valid = 1'b1;
        tick();
        done_valid = 1'b1; done_idx = 4'd5;
        in_inst = mk(3'd2, 4'd5, 4'd3, 4'd4, 12'h020);
        tick();
        done_valid = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL setwin_stall: got %b want 0", out_valid); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL setwin_count: got %0d want 1", count); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL setwin_stall2: got %b want 0", out_valid); end
        done_valid = 1'b1; done_idx = 4'd5;
        tick();
        done_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL setwin_release: got %b want 1", out_valid); end
        tick();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL setwin_drain: got %0d want 0", count); end
    endtask

    task automatic test_nop_and_flush();
        logic [26:0] k [4];
        clear_all();
        k[0] = mk(3'd1, 4'd1, 4'd2, 4'd10, 12'h001);
        k[1] = mk(3'd0, 4'd0, 4'd0, 4'd0,  12'h5A5);
        k[2] = mk(3'd2, 4'd3, 4'd4, 4'd11, 12'h003);
        k[3] = mk(3'd3, 4'd5, 4'd6, 4'd12, 12'h004);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_inst = k[i]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL nop_count4: got %0d want 4", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_inst !== k[1] || out_valid !== 1'b0) begin errors++; $display("FAIL nop_head: got %h/%b want %h/0", out_inst, out_valid, k[1]); end
        tick();
        checks++; if (out_inst !== k[2] || out_valid !== 1'b1) begin errors++; $display("FAIL nop_popped: got %h/%b want %h/1", out_inst, out_valid, k[2]); end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL nop_count2: got %0d want 2", count); end
        flush = 1'b1; in_inst = mk(3'd4, 4'd7, 4'd7, 4'd7, 12'h777); in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        checks++; if (out_inst !== 27'd0) begin errors++; $display("FAIL flush_inst: got %h want 0", out_inst); end
        // Index 10 was busy before the flush.
        in_inst = mk(3'd1, 4'd10, 4'd10, 4'd13, 12'h0F0); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_scoreboard: got %b want 1", out_valid); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL flush_push_after: got %0d want 1", count); end
    endtask

    task automatic test_reset_mid();
        // Entry from the previous test is queued; make index 13 busy, then reset.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_inst = mk(3'd2, 4'd13, 4'd0, 4'd14, 12'h0AA); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_pre: got %b want 0", out_valid); end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", count); end
        in_inst = mk(3'd2, 4'd13, 4'd0, 4'd14, 12'h0AA); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_scoreboard: got %b want 1", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_raw_hazard();
        test_full_and_back_to_back();
        test_set_wins();
        test_nop_and_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
